// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature macro: LOADER_CHECKSUM_EN (enables the trailing checksum byte).
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned BYTE_BITS  = 8;

   // Byte lanes in arrival order: the first byte lands in lane 3 ([31:24]).
   localparam int unsigned LANE_FIRST = WORD_BYTES - 1;
   localparam int unsigned LANE_LAST  = 0;

   // Byte-counter value at which the incoming byte completes a word.
   localparam logic [1:0] LAST_BYTE_CNT = 2'(WORD_BYTES - 1);

   // Byte address of a word index relative to a base.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Big-endian byte-to-word packer: 2-bit byte counter, shift register of the
// earlier bytes, and a word_full pulse on the byte that completes a word.
module imem_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  din,
   output logic [31:0] word_next,
   output logic        word_full
);

   logic [1:0]                       cnt;
   logic [LANE_FIRST*BYTE_BITS-1:0]  sreg;

   // Present the word as it will be once the current byte is taken.
   always_comb begin
      word_next = '0;
      word_next[31:BYTE_BITS] = sreg;
      word_next[LANE_LAST*BYTE_BITS +: BYTE_BITS] = din;
   end

   assign word_full = accept && (cnt == LAST_BYTE_CNT);

   // Count accepted bytes and shift earlier ones toward the high lanes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         sreg <= '0;
      end else if (clear) begin
         cnt  <= '0;
         sreg <= '0;
      end else if (accept) begin
         cnt  <= cnt + 2'd1;
         sreg <= {sreg[(LANE_FIRST-1)*BYTE_BITS-1:0], din};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream, packs big-endian words
// and writes them to consecutive (wrapping) word addresses while holding the
// fetch stage via busy. Optional feature macro: LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [10:0] word_count,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t             state;
   logic [10:0]        count;
   logic [10:0]        index;
   logic [PTR_W-1:0]   ptr;
   logic [31:0]        word_next;
   logic               word_full;
   logic               accept;

   // Payload bytes only; the checksum byte in CHECK never enters the packer.
   assign accept = in_valid && in_ready && (state == RECV);

   imem_byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (state == IDLE),
      .accept    (accept),
      .din       (in_data),
      .word_next (word_next),
      .word_full (word_full)
   );

   // Loader FSM with registered handshake, write and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         index    <= '0;
         ptr      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_en    <= 1'b0;
         in_ready <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         done  <= 1'b0;
         wr_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  count <= word_count;
                  index <= '0;
                  ptr   <= '0;
                  busy  <= 1'b1;
                  if (word_count == 11'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= RECV;
                     in_ready <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (word_full) begin
                  state    <= WRITE;
                  in_ready <= 1'b0;
                  wr_en    <= 1'b1;
                  wr_data  <= word_next;
                  wr_addr  <= word_addr(BASE_ADDR, 32'(ptr));
                  index    <= index + 11'd1;
                  ptr      <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
               end
            end
            WRITE: begin
               if (index != count) begin
                  state    <= RECV;
                  in_ready <= 1'b1;
               end else begin
`ifdef LOADER_CHECKSUM_EN
                  state    <= CHECK;
                  in_ready <= 1'b1;
`else
                  state    <= DONE;
                  done     <= 1'b1;
`endif
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
               if (in_valid && in_ready) begin
                  state    <= DONE;
                  in_ready <= 1'b0;
                  done     <= 1'b1;
               end
            end
`endif
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum;

   // Running sum of payload bytes; err latches the checksum verdict until the next load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
         err <= 1'b0;
      end else if (state == IDLE && start) begin
         sum <= '0;
         err <= 1'b0;
      end else if (accept) begin
         sum <= sum + in_data;
      end else if (state == CHECK && in_valid && in_ready) begin
         err <= (in_data != sum);
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the instruction memory size in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 0, giving the byte address of word 0.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a load.
REQ-006 The block SHALL have port word_count, input, 11 bits, the number of words to load, sampled with start.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning the byte source presents in_data.
REQ-008 The block SHALL have port in_data, input, 8 bits, the stream byte.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the loader accepts a byte this cycle.
REQ-010 The block SHALL have port wr_en, output, 1 bit, the instruction-memory write strobe.
REQ-011 The block SHALL have port wr_addr, output, 32 bits, the word-aligned byte address with bits [1:0] = 0.
REQ-012 The block SHALL have port wr_data, output, 32 bits, the assembled instruction word.
REQ-013 The block SHALL have port busy, output, 1 bit, which holds the fetch stage (PC reset/stall) during a load.
REQ-014 The block SHALL have ports done (1 bit, one-cycle completion pulse) and err (1 bit, checksum failure), both outputs.

Function
REQ-015 The FSM SHALL have states IDLE, RECV, WRITE, CHECK and DONE.
REQ-016 In IDLE, start=1 SHALL latch word_count, clear the word index and byte counter, and move to RECV; if word_count=0 it SHALL move to DONE with no write.
REQ-017 A byte SHALL be accepted only on in_valid&in_ready, and in_ready SHALL be 1 only in RECV and CHECK.
REQ-018 Bytes SHALL be packed big-endian: the first byte goes to [31:24] and the fourth to [7:0].
REQ-019 Acceptance of the fourth byte SHALL move the FSM to WRITE, so wr_en=1 for exactly one cycle on the next cycle, carrying wr_data.
REQ-020 wr_addr SHALL equal BASE_ADDR + 4*(index mod DEPTH), so an index of DEPTH or more wraps to word 0.
REQ-021 After WRITE, the FSM SHALL return to RECV if words remain; otherwise it SHALL go to CHECK when LOADER_CHECKSUM_EN is defined, or to DONE when it is not.
REQ-022 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-023 busy SHALL be 1 from the cycle after start through the DONE cycle inclusive.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 in_valid stalls SHALL only pause the transfer, with no timeout.
REQ-026 wr_en, in_ready, done and busy SHALL be 0 in IDLE.

Reset
REQ-027 rst SHALL force IDLE immediately and clear busy, done, wr_en, in_ready, err, wr_addr, wr_data, the index and the byte counter to 0.
REQ-028 A reset during a load SHALL discard any partial word with no write.

Configuration
REQ-029 With LOADER_CHECKSUM_EN defined, the block SHALL keep an 8-bit running sum of all payload bytes, and CHECK SHALL accept one extra byte.
REQ-030 With LOADER_CHECKSUM_EN defined, err SHALL be set when the extra byte differs from the sum, and SHALL hold until the next accepted start.
REQ-031 Without LOADER_CHECKSUM_EN, CHECK and the sum SHALL be absent, and err SHALL be tied to 0.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef, WORD_BYTES=4 and the byte-lane index constants.
REQ-033 The byte packer SHALL be the sub-module imem_byte_packer (2-bit counter, shift register, word_full pulse), instantiated once.

Verification
REQ-034 Bench: start, word_count=2, bytes 80 01 06 0A 90 01 10 00 with no stalls -> writes (0x0,0x8001060A), then (0x4,0x90011000), then a done pulse, and busy falls after DONE.
REQ-035 Bench: word_count=0 -> done on the second cycle after start, with no wr_en.
REQ-036 Bench: in_valid low for 5 cycles between bytes 2 and 3 -> the same word is written and in_ready is 0 only in WRITE.
REQ-037 Bench: DEPTH=4, word_count=5 -> fifth write at wr_addr 0x0.
REQ-038 Bench: rst after 3 bytes of word 1 -> no write, IDLE and all outputs 0; a new start loads correctly.
REQ-039 Bench (LOADER_CHECKSUM_EN): word 01 02 03 04 with checksum 0A -> err=0; with checksum 0B -> err=1.
